// File: rtl/bq_uart_pkg.sv
// Shared types and constants for the bq UART frame path.
package bq_uart_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned MAX_LEN_DEF = 128;
    localparam int unsigned CRC_BYTES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DATA,
        ST_RD0,
        ST_RD1,
        ST_SEND0,
        ST_SEND1,
        ST_DONE
    } tx_state_e;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Mid-frame idle-gap counter; expire pulses on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module frame_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic sclk,
    input  logic reset,
    input  logic clear,
    input  logic cnt_en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] gap_cnt;

    always_ff @(posedge sclk) begin
        if (reset || clear) begin
            gap_cnt <= '0;
        end else if (cnt_en && !expire) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
        end
    end

    assign expire = cnt_en && (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bq_frame_tx_ctrl.sv
// Frame transmit sequencer: payload pass-through to UART with CRC16 engine sequencing and CRC tail.
// Optional mid-frame idle timeout is built when FRAME_TIMEOUT_EN is defined.
module bq_frame_tx_ctrl
    import bq_uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = MAX_LEN_DEF,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              crc_init,
    output logic              crc_en,
    output logic [BYTE_W-1:0] crc_data,
    output logic              crc_rd,
    input  logic [15:0]       crc_out,
    input  logic              crc_end,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  frame_len
);

    tx_state_e         state;
    logic [BYTE_W-1:0] hold [CRC_BYTES];
    logic              len_err;
    logic              seq_err;
    logic              to_err;
    logic              gap_expire;

`ifdef FRAME_TIMEOUT_EN
    frame_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_cnt (
        .sclk  (sclk),
        .reset (reset),
        .clear (state != ST_DATA || in_valid),
        .cnt_en(state == ST_DATA && !in_valid),
        .expire(gap_expire)
    );
`else
    assign gap_expire = 1'b0;
    logic unused_timeout;
    assign unused_timeout = &{1'b0, 32'(TIMEOUT_CYCLES), gap_expire};
`endif

    logic unused_crc_hi;
    assign unused_crc_hi = &{1'b0, crc_out[15:BYTE_W]};

    // Sequencer: state, byte count, error flags, CRC hold bytes and status pulses
    always_ff @(posedge sclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame_len <= '0;
            len_err   <= 1'b0;
            seq_err   <= 1'b0;
            to_err    <= 1'b0;
            hold[0]   <= '0;
            hold[1]   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_INIT;
                        busy  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    frame_len <= '0;
                    len_err   <= 1'b0;
                    seq_err   <= 1'b0;
                    to_err    <= 1'b0;
                    state     <= ST_DATA;
                end
                ST_DATA: begin
                    if (in_valid && tx_ready) begin
                        frame_len <= frame_len + LEN_W'(1);
                        // MAX_LEN-th byte closes the frame; only an error if it was not marked last
                        if (in_last || frame_len == LEN_W'(MAX_LEN - 1)) begin
                            len_err <= !in_last;
                            state   <= ST_RD0;
                        end
                    end else if (gap_expire) begin
                        to_err <= 1'b1;
                        state  <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    hold[0] <= crc_out[BYTE_W-1:0];
                    state   <= ST_RD1;
                end
                ST_RD1: begin
                    hold[1] <= crc_out[BYTE_W-1:0];
                    if (!crc_end) begin
                        seq_err <= 1'b1;
                    end
                    state <= ST_SEND0;
                end
                ST_SEND0: begin
                    if (tx_ready) begin
                        state <= ST_SEND1;
                    end
                end
                ST_SEND1: begin
                    if (tx_ready) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= len_err | seq_err | to_err;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stream and engine strobes decoded from state; only one engine strobe per state
    always_comb begin
        in_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        crc_data = '0;
        crc_rd   = 1'b0;
        case (state)
            ST_INIT: crc_init = 1'b1;
            ST_DATA: begin
                tx_valid = in_valid;
                tx_data  = in_data;
                in_ready = tx_ready;
                crc_en   = in_valid & tx_ready;
                crc_data = in_data;
            end
            ST_RD0, ST_RD1: crc_rd = 1'b1;
            ST_SEND0: begin
                tx_valid = 1'b1;
                tx_data  = hold[0];
            end
            ST_SEND1: begin
                tx_valid = 1'b1;
                tx_data  = hold[1];
                tx_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bq_frame_tx_ctrl.sv
// Bench for bq_frame_tx_ctrl: CRC16 engine stand-in, frame-level reference model, directed and random traffic.
module tb_bq_frame_tx_ctrl;

    localparam int unsigned MAX_LEN        = 8;
    localparam int unsigned LEN_W          = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic             sclk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             tx_ready;
    logic             crc_init;
    logic             crc_en;
    logic [7:0]       crc_data;
    logic             crc_rd;
    logic [15:0]      crc_out;
    logic             crc_end;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] frame_len;

    bq_frame_tx_ctrl #(
        .MAX_LEN       (MAX_LEN),
        .LEN_W         (LEN_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .sclk     (sclk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .crc_init (crc_init),
        .crc_en   (crc_en),
        .crc_data (crc_data),
        .crc_rd   (crc_rd),
        .crc_out  (crc_out),
        .crc_end  (crc_end),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .frame_len(frame_len)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Modbus-style CRC16 (reflected 0x8005, init 0xFFFF), one byte at a time
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc_of(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) c = crc_step(c, d[i]);
        return c;
    endfunction

    // CRC16_D8 stand-in: each read presents the low byte then shifts the register down
    logic [15:0] eng_crc;
    int          eng_rd;
    always @(posedge sclk) begin
        if (reset || crc_init) begin
            eng_crc <= 16'hFFFF;
            eng_rd  <= 0;
        end else if (crc_en) begin
            eng_crc <= crc_step(eng_crc, crc_data);
        end else if (crc_rd) begin
            eng_crc <= {8'h00, eng_crc[15:8]};
            eng_rd  <= eng_rd + 1;
        end
    end
    assign crc_out = eng_crc;
    assign crc_end = (eng_rd == 1);

    // UART-side ready: random or held high unless the main thread asks for a stall
    bit rdy_random = 1'b0;
    bit hold_low   = 1'b0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge sclk);
            #2;
            tx_ready = rdy_random ? ($urandom_range(0, 9) < 7) : !hold_low;
        end
    end

    typedef struct {
        int len;
        bit err;
        int lat;
    } done_rec_t;

    logic [7:0] got_d[$];
    bit         got_l[$];
    done_rec_t  done_q[$];
    int         cyc = 0;
    int         last_hs_cyc = 0;
    int         init_cyc = 0;
    int         first_hs_cyc = 0;
    bit         first_pending = 1'b0;
    int         rd_cnt = 0;
    int         en_cnt = 0;
    int         excl_viol = 0;

    // Monitor samples mid-cycle; a handshake seen here completes on the next rising edge
    always @(negedge sclk) begin
        done_rec_t r;
        cyc++;
        if (!reset) begin
            assert (int'(crc_init) + int'(crc_en) + int'(crc_rd) <= 1)
            else excl_viol++;
            if (crc_init) begin
                init_cyc      = cyc;
                first_pending = 1'b1;
            end
            if (crc_rd) rd_cnt++;
            if (crc_en) en_cnt++;
            if (in_valid && in_ready) begin
                last_hs_cyc = cyc;
                if (first_pending) begin
                    first_hs_cyc  = cyc;
                    first_pending = 1'b0;
                end
            end
            if (tx_valid && tx_ready) begin
                got_d.push_back(tx_data);
                got_l.push_back(tx_last);
            end
            if (done) begin
                r.len = int'(frame_len);
                r.err = err;
                r.lat = cyc - last_hs_cyc;
                done_q.push_back(r);
            end
        end
    end

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    int         exp_len[$];
    bit         exp_err[$];

    // Reference: split the byte stream into frames at in_last or MAX_LEN, append CRC low then high
    task automatic build_expect(input logic [7:0] d[$], input bit l[$], input bit close_open);
        logic [7:0] fr[$];
        logic [15:0] c;
        exp_d.delete(); exp_l.delete(); exp_len.delete(); exp_err.delete();
        for (int i = 0; i < d.size(); i++) begin
            fr.push_back(d[i]);
            if (l[i] || fr.size() == MAX_LEN || (close_open && i == d.size() - 1)) begin
                c = crc_of(fr);
                foreach (fr[j]) begin
                    exp_d.push_back(fr[j]);
                    exp_l.push_back(1'b0);
                end
                exp_d.push_back(c[7:0]);
                exp_l.push_back(1'b0);
                exp_d.push_back(c[15:8]);
                exp_l.push_back(1'b1);
                exp_len.push_back(fr.size());
                exp_err.push_back(!l[i]);
                fr.delete();
            end
        end
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        done_q.delete();
        rd_cnt = 0;
        en_cnt = 0;
    endtask

    task automatic drive(input logic [7:0] d[$], input bit l[$], input int max_gap);
        int gap;
        int k;
        bit hs;
        for (int i = 0; i < d.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge sclk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = l[i];
            hs = 1'b0;
            k  = 0;
            while (!hs && k < 200) begin
                @(negedge sclk);
                hs = in_ready;
                @(posedge sclk);
                #1;
                k++;
            end
            if (!hs) check("drive_handshake", 32'(hs), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge sclk);
            k++;
        end
        repeat (2) @(posedge sclk);
        #1;
        check("done_count", 32'(done_q.size()), 32'(n));
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s_nbytes", tag), 32'(got_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
        end
        for (int i = 0; i < exp_len.size() && i < done_q.size(); i++) begin
            check($sformatf("%s_len%0d", tag, i), 32'(done_q[i].len), 32'(exp_len[i]));
            check($sformatf("%s_err%0d", tag, i), 32'(done_q[i].err), 32'(exp_err[i]));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        bit         l[$];
        logic [7:0] modbus[$];
        bit         modbus_l[$];

        modbus   = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        modbus_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check("reset_outputs", 32'({busy, done, err, tx_valid, tx_last, in_ready,
                                    crc_init, crc_en, crc_rd, crc_data, tx_data, frame_len}), 32'd0);
        reset = 1'b0;
        @(posedge sclk);
        #1;

        // Normal frame with the known Modbus tail 84 0A
        clear_mon();
        build_expect(modbus, modbus_l, 1'b0);
        drive(modbus, modbus_l, 0);
        wait_done(1, 100);
        compare_all("normal");
        if (got_d.size() >= 8) begin
            check("normal_crc_lo", 32'(got_d[6]), 32'h84);
            check("normal_crc_hi", 32'(got_d[7]), 32'h0A);
        end
        if (done_q.size() >= 1) check("normal_done_latency", 32'(done_q[0].lat), 32'd5);
        check("normal_init_to_first_hs", 32'(first_hs_cyc - init_cyc), 32'd1);
        check("normal_rd_cycles", 32'(rd_cnt), 32'd2);
        check("normal_en_cycles", 32'(en_cnt), 32'd6);
        check("normal_frame_len_held", 32'(frame_len), 32'd6);
        check("normal_idle_busy", 32'(busy), 32'd0);

        // Back-pressure: stall the first CRC byte for three cycles
        clear_mon();
        build_expect(modbus, modbus_l, 1'b0);
        drive(modbus, modbus_l, 0);
        @(posedge sclk); #1;
        @(posedge sclk); #1;
        hold_low = 1'b1;
        repeat (3) begin
            @(negedge sclk);
            check("bp_stall_hold", 32'({tx_valid, tx_ready, tx_data}), 32'({1'b1, 1'b0, 8'h84}));
            @(posedge sclk);
        end
        #1;
        hold_low = 1'b0;
        wait_done(1, 100);
        compare_all("bp");
        check("bp_rd_cycles", 32'(rd_cnt), 32'd2);
        check("bp_en_cycles", 32'(en_cnt), 32'd6);

        // Exactly MAX_LEN bytes with in_last on the final one is a clean frame
        clear_mon();
        d.delete(); l.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            d.push_back(8'($urandom));
            l.push_back(i == MAX_LEN - 1);
        end
        build_expect(d, l, 1'b0);
        drive(d, l, 0);
        wait_done(1, 100);
        compare_all("boundary");
        if (done_q.size() >= 1) check("boundary_no_err", 32'(done_q[0].err), 32'd0);

        // Overflow: MAX_LEN+2 bytes, last only on the final byte -> forced split
        clear_mon();
        d.delete(); l.delete();
        for (int i = 0; i < MAX_LEN + 2; i++) begin
            d.push_back(8'($urandom));
            l.push_back(i == MAX_LEN + 1);
        end
        build_expect(d, l, 1'b0);
        drive(d, l, 0);
        wait_done(2, 200);
        compare_all("overflow");
        if (done_q.size() >= 1) begin
            check("overflow_len", 32'(done_q[0].len), 32'(MAX_LEN));
            check("overflow_err", 32'(done_q[0].err), 32'd1);
        end

        // Reset after three payload bytes aborts the frame
        clear_mon();
        d = '{8'h11, 8'h22, 8'h33};
        l = '{1'b0, 1'b0, 1'b0};
        drive(d, l, 0);
        reset = 1'b1;
        @(posedge sclk);
        #1;
        check("midreset_outputs", 32'({busy, done, err, tx_valid, tx_last, in_ready,
                                       crc_init, crc_en, crc_rd, crc_data, tx_data, frame_len}), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge sclk);
        #1;
        check("midreset_no_done", 32'(done_q.size()), 32'd0);
        clear_mon();
        build_expect(modbus, modbus_l, 1'b0);
        drive(modbus, modbus_l, 0);
        wait_done(1, 100);
        compare_all("after_reset");
        if (got_d.size() >= 8) check("after_reset_tail", 32'({got_d[6], got_d[7]}), 32'h840A);

`ifdef FRAME_TIMEOUT_EN
        // Two bytes then silence: frame closed by the idle timeout
        clear_mon();
        d = '{8'hA5, 8'h5A};
        l = '{1'b0, 1'b0};
        build_expect(d, l, 1'b1);
        drive(d, l, 0);
        wait_done(1, 200);
        compare_all("timeout");
        if (done_q.size() >= 1) check("timeout_err", 32'(done_q[0].err), 32'd1);
`endif

        // Random traffic with random gaps and UART back-pressure
        clear_mon();
        rdy_random = 1'b1;
        d.delete(); l.delete();
        for (int i = 0; i < 120; i++) begin
            d.push_back(8'($urandom));
            l.push_back((i == 119) || ($urandom_range(0, 3) == 0));
        end
        build_expect(d, l, 1'b0);
        drive(d, l, 3);
        wait_done(exp_len.size(), 20000);
        compare_all("random");
        rdy_random = 1'b0;

        check("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bq_frame_tx_ctrl.md
# bq_frame_tx_ctrl

Frame transmit sequencer that sits between the command-frame builder and the UART transmitter, and owns the byte-wide CRC16 engine (`CRC16_D8`). For each frame it initialises the engine and forwards payload bytes to the UART while feeding them to the engine. It then reads the two CRC bytes out, buffers them, and transmits them as the frame tail. It guarantees the engine's `init`, `data_en` and `CRC_rd` strobes are never asserted together.

## Interface
- `MAX_LEN`, 128: maximum payload bytes per frame, CRC excluded.
- `LEN_W`, 8: width of the byte counter; must satisfy `2^LEN_W > MAX_LEN`.
- `TIMEOUT_CYCLES`, 1024: idle-gap limit used only when `FRAME_TIMEOUT_EN` is defined.

Ports:
- `sclk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1, `in_data` in 8, `in_last` in 1, `in_ready` out 1: payload stream from the frame builder.
- `tx_valid` out 1, `tx_data` out 8, `tx_last` out 1, `tx_ready` in 1: byte stream to the UART TX.
- `crc_init` out 1, `crc_en` out 1, `crc_data` out 8, `crc_rd` out 1: strobes to the engine's `init` / `data_en` / `Frame_data` / `CRC_rd`.
- `crc_out` in 16, `crc_end` in 1: engine outputs; only `crc_out[7:0]` is used.
- `busy` out 1, `done` out 1, `err` out 1, `frame_len` out `LEN_W`: status outputs.

## Operation
The state machine has eight states: IDLE, INIT, DATA, RD0, RD1, SEND0, SEND1, DONE.

- **IDLE**
  - `in_ready`=0.
  - `in_valid`=1 → INIT. The byte stays pending and is not consumed.
- **INIT**
  - `crc_init`=1 for exactly one cycle.
  - Byte counter cleared; error flags cleared.
  - → DATA.
- **DATA**
  - Pass-through: `tx_valid`=`in_valid`, `tx_data`=`in_data`, `in_ready`=`tx_ready`.
  - `crc_en`=`in_valid & tx_ready`, `crc_data`=`in_data` (raw; the engine bit-reverses internally).
  - Each handshake increments the counter.
  - Exit to RD0 when the accepted byte has `in_last`=1, or when it is byte number `MAX_LEN`. In the second case the `MAX_LEN`-th byte force-terminates the frame and the length-error flag is set.
- **RD0**
  - `crc_rd`=1; `crc_out[7:0]` captured into hold0.
  - → RD1.
- **RD1**
  - `crc_rd`=1; `crc_out[7:0]` captured into hold1.
  - `crc_end` must be 1 in this cycle; otherwise the sequence-error flag is set.
  - → SEND0.
- **SEND0**
  - `tx_valid`=1, `tx_data`=hold0.
  - `tx_ready`=1 → SEND1.
- **SEND1**
  - `tx_valid`=1, `tx_data`=hold1, `tx_last`=1.
  - `tx_ready`=1 → DONE.
- **DONE**
  - `done`=1 for one cycle; `err` is the OR of the error flags, valid in the same cycle.
  - `frame_len` holds the payload count until the next INIT.
  - → IDLE.

Invariants:
- `busy`=1 in every state except IDLE.
- At most one of `crc_init` / `crc_en` / `crc_rd` is asserted in any cycle.
- `crc_rd` is high for exactly two consecutive cycles per frame. The engine shifts on each of those cycles regardless of `tx_ready`, which is why both CRC bytes are buffered before SEND0.

## Timing
- Reset value of every output is 0, including `frame_len`; the state resets to IDLE.
- Reset mid-frame aborts immediately. No CRC tail is sent and `done` is not pulsed. The engine shares `reset` and returns to 0xFFFF.
- First payload byte: `in_valid` at cycle t → INIT at t+1 → earliest handshake at t+2.
- Tail: last payload handshake at cycle n → RD0 n+1, RD1 n+2, SEND0 `tx_valid` n+3.
- With `tx_ready` held high, `done` is at n+5.
- `tx_ready` low in SEND0/SEND1 stalls that state with `tx_data` held stable.
- `in_valid` low in DATA stalls with no CRC update.
- `MAX_LEN` boundary: a byte with `in_last`=1 at count `MAX_LEN` is a normal frame, so `err`=0.
- Counter width: the count never exceeds `MAX_LEN`, so there is no wrap.

## Configuration
`FRAME_TIMEOUT_EN` controls the mid-frame idle timeout.

- **Defined:**
  - In DATA, a gap counter counts consecutive cycles with `in_valid`=0 and resets on any `in_valid`.
  - On reaching `TIMEOUT_CYCLES` the timeout flag is set and the state moves to RD0, so the frame is closed with the CRC of the bytes received so far.
  - `err`=1 at DONE.
- **Undefined:** no counter exists and DATA waits indefinitely.

## Structure
- **Shared package `bq_uart_pkg`:**
  - state enum;
  - `BYTE_W`=8;
  - default `MAX_LEN`;
  - `CRC_BYTES`=2.
- **One sub-module, `frame_timeout_cnt`:**
  - ports: clear, count-enable, expire output;
  - parameterised by `TIMEOUT_CYCLES`;
  - instantiated only under `FRAME_TIMEOUT_EN`.
- `CRC16_D8` is connected beside this block at the parent level, not inside it.

## Test plan
- **Normal frame:** send 01 03 00 00 00 01 (`in_last` on the 6th), `tx_ready`=1 → tx stream 01 03 00 00 00 01 84 0A, `tx_last` on 0A, `frame_len`=6, `err`=0, `done` 5 cycles after the last payload handshake.
- **Back-pressure:** same frame with `tx_ready` low for 3 cycles during SEND0 → `crc_rd` is still exactly 2 cycles, output is still 84 0A, and `crc_en` count is 6.
- **Length overflow:** `MAX_LEN`=4, 6 bytes with no `in_last` → 4 bytes plus CRC sent, `frame_len`=4, `err`=1; remaining input starts a new frame.
- **Reset mid-frame:** `reset` after 3 bytes → all outputs 0 next cycle, no `done`; the following frame 01 03 00 00 00 01 still yields 84 0A.
- **Timeout** (`FRAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): 2 bytes then 16 idle cycles → CRC tail sent, `err`=1.
- **Strobe exclusivity:** an assertion checks `crc_init`+`crc_en`+`crc_rd` ≤ 1 every cycle across random traffic.
